// File: rtl/inner_loop_pkg.sv
// Shared blitter definitions: memory cycle encodings, inner-loop state
// encoding, command register bit positions and phase-sequencing helpers.
package inner_loop_pkg;

   localparam logic [1:0] CYC_SREAD  = 2'b00;
   localparam logic [1:0] CYC_DREAD  = 2'b01;
   localparam logic [1:0] CYC_DWRITE = 2'b10;

   localparam int SRCEN_BIT = 0;
   localparam int DSTEN_BIT = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SREAD  = 2'd1,
      DREAD  = 2'd2,
      DWRITE = 2'd3
   } state_t;

   // First memory phase of a pixel; destination write always runs.
   function automatic state_t first_phase(input logic srcen, input logic dsten);
      if (srcen)
         return SREAD;
      else if (dsten)
         return DREAD;
      else
         return DWRITE;
   endfunction

   // Phase that follows an acknowledged phase; last marks the final pixel.
   function automatic state_t after_phase(input state_t s, input logic srcen,
                                          input logic dsten, input logic last);
      case (s)
         SREAD:   return dsten ? DREAD : DWRITE;
         DREAD:   return DWRITE;
         DWRITE:  return last ? IDLE : first_phase(srcen, dsten);
         default: return IDLE;
      endcase
   endfunction

   function automatic logic [1:0] cyc_of(input state_t s);
      case (s)
         DREAD:   return CYC_DREAD;
         DWRITE:  return CYC_DWRITE;
         default: return CYC_SREAD;
      endcase
   endfunction

endpackage

// File: rtl/inner_loop_cnt.sv
// Inner pixel counter: shadow register loaded by the GPU, working down-counter
// snapshotted at pass start (with same-cycle bypass), decrement and is_one flag.
module inner_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             countld,
   input  logic [CNT_W-1:0] din,
   input  logic             start,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             is_one
);

   logic [CNT_W-1:0] shadow;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow <= '0;
         count  <= '0;
      end else begin
         if (countld)
            shadow <= din;
         if (start)
            count <= countld ? din : shadow;
         else if (dec)
            count <= count - 1'b1;
      end
   end

   // A start value of 0 wraps to all-ones, giving 2^CNT_W pixels.
   assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/inner_loop.sv
// Blitter inner-loop sequencer: runs source read / destination read /
// destination write phases per pixel over a req/ack memory handshake.
// Optional status readback of the working count under `INNER_STAT_EN.
module inner_loop
   import inner_loop_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      gpu_din,
   input  logic             cmdld,
   input  logic             countld,
   input  logic             instart,
   input  logic             stopped,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic [1:0]       cyc_type,
   output logic             inner_busy,
`ifdef INNER_STAT_EN
   input  logic             statrd,
   output logic [CNT_W-1:0] gpu_dout_out,
   output logic             gpu_dout_oe,
`endif
   output logic             indone
);

   state_t           state;
   state_t           phase_next;
   logic             srcen;
   logic             dsten;
   logic             run_srcen;
   logic             run_dsten;
   logic             ack_ok;
   logic             start;
   logic             is_one;
   logic [CNT_W-1:0] work_count;

   assign ack_ok     = mem_req & mem_ack;
   assign start      = (state == IDLE) & instart;
   assign phase_next = after_phase(state, run_srcen, run_dsten, is_one);

   inner_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .countld (countld),
      .din     (gpu_din[CNT_W-1:0]),
      .start   (start),
      .dec     ((state == DWRITE) & ack_ok),
      .count   (work_count),
      .is_one  (is_one)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         srcen <= 1'b0;
         dsten <= 1'b0;
      end else if (cmdld) begin
         srcen <= gpu_din[SRCEN_BIT];
         dsten <= gpu_din[DSTEN_BIT];
      end
   end

   // Phase enables in use are snapshotted at start so cmdld mid-pass is harmless.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         cyc_type   <= CYC_SREAD;
         indone     <= 1'b0;
         inner_busy <= 1'b0;
         run_srcen  <= 1'b0;
         run_dsten  <= 1'b0;
      end else begin
         indone <= 1'b0;
         if (state == IDLE) begin
            mem_req <= 1'b0;
            if (instart) begin
               run_srcen  <= srcen;
               run_dsten  <= dsten;
               state      <= first_phase(srcen, dsten);
               cyc_type   <= cyc_of(first_phase(srcen, dsten));
               inner_busy <= 1'b1;
            end
         end else if (ack_ok) begin
            mem_req    <= 1'b0;
            state      <= phase_next;
            cyc_type   <= cyc_of(phase_next);
            inner_busy <= (phase_next != IDLE);
            indone     <= (phase_next == IDLE);
         end else if (!stopped) begin
            // An outstanding request simply holds; stopped only blocks raising it.
            mem_req <= 1'b1;
         end
      end
   end

   logic unused_sink;

`ifdef INNER_STAT_EN
   assign gpu_dout_out = work_count;
   assign gpu_dout_oe  = statrd;
   assign unused_sink  = ^(gpu_din >> CNT_W);
`else
   assign unused_sink  = ^{gpu_din >> CNT_W, work_count};
`endif

endmodule
